tiny_proc_core: RTL and testbench



---
 rtl/tiny_proc_pkg.sv | 27 ++
 rtl/tiny_proc_alu.sv | 39 +++
 rtl/tiny_proc_core.sv | 137 +++++++++++++
 tb/tb_tiny_proc_core.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tiny_proc_pkg.sv
// rtl/tiny_proc_pkg.sv - opcode values and control state encoding for tiny_proc_core
package tiny_proc_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_SLL  = 4'h2;
  localparam logic [3:0] OP_BNZ  = 4'h3;
  localparam logic [3:0] OP_SRL  = 4'h4;
  localparam logic [3:0] OP_MUL  = 4'h5;
  localparam logic [3:0] OP_NAND = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_LI   = 4'h9;
  localparam logic [3:0] OP_SLLI = 4'hA;
  localparam logic [3:0] OP_SRLI = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hC;
  localparam logic [3:0] OP_CLR  = 4'hD;
  localparam logic [3:0] OP_LA   = 4'hE;
  localparam logic [3:0] OP_SA   = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/tiny_proc_alu.sv
// rtl/tiny_proc_alu.sv - combinational accumulator update for one instruction
module tiny_proc_alu
  import tiny_proc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OPND_W = 4
) (
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] d,
  input  logic [OPND_W-1:0] operand,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W-1:0] imm;

  // Shift amounts at or beyond DATA_W naturally yield zero with logical shifts.
  always_comb begin
    imm    = DATA_W'($signed(operand));
    result = acc;
    case (opcode)
      OP_ADD:  result = acc + d;
      OP_SUB:  result = acc - d;
      OP_SLL:  result = acc << d;
      OP_SRL:  result = acc >> d;
      OP_MUL:  result = acc * d;
      OP_NAND: result = ~(acc & d);
      OP_XOR:  result = acc ^ d;
      OP_ADDI: result = acc + imm;
      OP_LI:   result = imm;
      OP_SLLI: result = acc << operand;
      OP_SRLI: result = acc >> operand;
      OP_CLR:  result = '0;
      OP_LA:   result = d;
      default: result = acc;
    endcase
  end

endmodule

// File: rtl/tiny_proc_core.sv
// rtl/tiny_proc_core.sv - accumulator core with run/step/halt control, IMEM load port and DMEM debug read
module tiny_proc_core
  import tiny_proc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OPND_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_valid,
  output logic              prog_ready,
  input  logic [OPND_W-1:0] prog_addr,
  input  logic [OPND_W+3:0] prog_data,
  input  logic              start,
  input  logic              step,
  input  logic              halt_req,
  input  logic [OPND_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [OPND_W-1:0] pc_o,
  output logic [DATA_W-1:0] acc_o,
  output logic [1:0]        state_o
);

  localparam int DEPTH = 2 ** OPND_W;
  localparam logic [OPND_W+3:0] HALT_WORD = {{OPND_W{1'b0}}, OP_HALT};
  localparam logic [OPND_W-1:0] PC_ONE = OPND_W'(1);

  state_e            state_q, state_d;
  logic [OPND_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] dbg_data_q, dbg_data_d;
  logic [OPND_W+3:0] imem_q [DEPTH];
  logic [DATA_W-1:0] dmem_q [DEPTH];

  logic [OPND_W+3:0] inst;
  logic [3:0]        opcode;
  logic [OPND_W-1:0] operand;
  logic [DATA_W-1:0] d_val;
  logic [DATA_W-1:0] alu_result;
  logic              exec;
  logic              imem_we;
  logic              dmem_we;

  tiny_proc_alu #(
    .DATA_W (DATA_W),
    .OPND_W (OPND_W)
  ) u_alu (
    .opcode  (opcode),
    .acc     (acc_q),
    .d       (d_val),
    .operand (operand),
    .result  (alu_result)
  );

  assign prog_ready = (state_q != ST_RUN);

  always_comb begin
    inst       = imem_q[pc_q];
    opcode     = inst[3:0];
    operand    = inst[OPND_W+3:4];
    d_val      = dmem_q[operand];
    dbg_data_d = dmem_q[dbg_addr];
    imem_we    = prog_valid && prog_ready;
    dmem_we    = 1'b0;
    exec       = 1'b0;
    state_d    = state_q;
    pc_d       = pc_q;
    acc_d      = acc_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          pc_d    = '0;
          acc_d   = '0;
        end else if (step) begin
          exec = 1'b1;
        end
      end
      ST_RUN:  exec = 1'b1;
      ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          pc_d    = '0;
          acc_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (exec) begin
      if (opcode == OP_HALT) begin
        state_d = ST_DONE;
      end else begin
        acc_d   = alu_result;
        dmem_we = (opcode == OP_SA);
        if (opcode == OP_BNZ) begin
          pc_d = (acc_q != '0) ? operand : pc_q + PC_ONE;
        end else if (&pc_q) begin
          state_d = ST_DONE;
        end else begin
          pc_d = pc_q + PC_ONE;
        end
        // A pending halt only applies while still running; DONE wins.
        if (state_q == ST_RUN && halt_req && state_d == ST_RUN) begin
          state_d = ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      acc_q      <= '0;
      dbg_data_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        imem_q[i] <= HALT_WORD;
        dmem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      acc_q      <= acc_d;
      dbg_data_q <= dbg_data_d;
      if (imem_we) imem_q[prog_addr] <= prog_data;
      if (dmem_we) dmem_q[operand]   <= acc_q;
    end
  end

  assign dbg_data = dbg_data_q;
  assign pc_o     = pc_q;
  assign acc_o    = acc_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_tiny_proc_core.sv
// tb/tb_tiny_proc_core.sv - self-checking bench for tiny_proc_core against an integer reference model
module tb_tiny_proc_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       prog_valid = 1'b0;
  logic       prog_ready;
  logic [3:0] prog_addr = '0;
  logic [7:0] prog_data = '0;
  logic       start = 1'b0;
  logic       step = 1'b0;
  logic       halt_req = 1'b0;
  logic [3:0] dbg_addr = '0;
  logic [7:0] dbg_data;
  logic [3:0] pc_o;
  logic [7:0] acc_o;
  logic [1:0] state_o;

  int n_cmp = 0;
  int n_bad = 0;

  int m_state, m_pc, m_acc, m_dbg;
  int m_imem [16];
  int m_dmem [16];

  tiny_proc_core #(.DATA_W(8), .OPND_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .prog_valid (prog_valid),
    .prog_ready (prog_ready),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .start      (start),
    .step       (step),
    .halt_req   (halt_req),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data),
    .pc_o       (pc_o),
    .acc_o      (acc_o),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_pc = 0; m_acc = 0; m_dbg = 0;
    for (int i = 0; i < 16; i++) begin
      m_imem[i] = 8'h0C;
      m_dmem[i] = 0;
    end
  endtask

  // One clock edge of the architectural rules, in plain integer arithmetic.
  task automatic model_step();
    int inst, op, opd, d, imm, res, ns, npc, nacc;
    bit ex, wr;
    wr    = prog_valid && (m_state != 1);
    m_dbg = m_dmem[dbg_addr];
    ns = m_state; npc = m_pc; nacc = m_acc; ex = 0;
    if (m_state != 1 && start) begin
      ns = 1; npc = 0; nacc = 0;
    end else if (m_state == 1 || (m_state == 0 && step)) begin
      ex = 1;
    end
    if (ex) begin
      inst = m_imem[m_pc];
      op   = inst % 16;
      opd  = inst / 16;
      d    = m_dmem[opd];
      imm  = (opd >= 8) ? opd + 240 : opd;
      if (op == 12) begin
        ns = 2;
      end else begin
        case (op)
          0:  res = (m_acc + d) % 256;
          1:  res = (m_acc - d + 256) % 256;
          2:  res = (d >= 8) ? 0 : (m_acc << d) % 256;
          4:  res = (d >= 8) ? 0 : m_acc >> d;
          5:  res = (m_acc * d) % 256;
          6:  res = 255 - (m_acc & d);
          7:  res = m_acc ^ d;
          8:  res = (m_acc + imm) % 256;
          9:  res = imm;
          10: res = (opd >= 8) ? 0 : (m_acc << opd) % 256;
          11: res = m_acc >> opd;
          13: res = 0;
          14: res = d;
          default: res = m_acc;
        endcase
        nacc = res;
        if (op == 15) m_dmem[opd] = m_acc;
        if (op == 3) npc = (m_acc != 0) ? opd : (m_pc + 1) % 16;
        else if (m_pc == 15) ns = 2;
        else npc = m_pc + 1;
        if (m_state == 1 && halt_req && ns == 1) ns = 0;
      end
    end
    if (wr) m_imem[prog_addr] = prog_data;
    m_state = ns; m_pc = npc; m_acc = nacc;
  endtask

  task automatic compare_model();
    check("state", {30'd0, state_o}, m_state);
    check("pc", {28'd0, pc_o}, m_pc);
    check("acc", {24'd0, acc_o}, m_acc);
    check("dbg_data", {24'd0, dbg_data}, m_dbg);
    check("prog_ready", {31'd0, prog_ready}, (m_state != 1) ? 1 : 0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic clear_inputs();
    prog_valid = 0; start = 0; step = 0; halt_req = 0;
  endtask

  // Reset asserted between edges; outputs are checked before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    #1;
    compare_model();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load(input int a, input int w);
    prog_valid = 1; prog_addr = 4'(a); prog_data = 8'(w);
    tick();
    prog_valid = 0;
  endtask

  task automatic do_start();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic run_until_done(output int edges);
    edges = 0;
    while (state_o != 2'd2 && edges < 200) begin
      tick();
      edges++;
    end
  endtask

  initial begin
    int e;
    int op;
    int basic [3] = '{8'h59, 8'h2F, 8'h0C};
    int loopp [6] = '{8'h19, 8'h1F, 8'h39, 8'h11, 8'h33, 8'h0C};
    int sgn   [8] = '{8'hE9, 8'h38, 8'h19, 8'h7A, 8'h4F, 8'h39, 8'h45, 8'h0C};
    int sgn_acc [7] = '{8'hFE, 8'h01, 8'h01, 8'h80, 8'h80, 8'h03, 8'h80};

    do_reset();

    for (int i = 0; i < 3; i++) load(i, basic[i]);
    step = 1; tick(); step = 0;
    check("step_acc", {24'd0, acc_o}, 5);
    check("step_pc", {28'd0, pc_o}, 1);
    check("step_state", {30'd0, state_o}, 0);
    do_start();
    run_until_done(e);
    check("basic_edges", e, 3);
    check("basic_acc", {24'd0, acc_o}, 5);
    check("basic_pc", {28'd0, pc_o}, 2);
    dbg_addr = 4'd2; tick();
    check("basic_dbg", {24'd0, dbg_data}, 5);

    for (int i = 0; i < 6; i++) load(i, loopp[i]);
    do_start();
    run_until_done(e);
    check("loop_edges", e, 10);
    check("loop_acc", {24'd0, acc_o}, 0);
    check("loop_pc", {28'd0, pc_o}, 5);
    dbg_addr = 4'd1; tick();
    check("loop_dmem1", {24'd0, dbg_data}, 1);

    do_start();
    prog_valid = 1; prog_addr = 4'd3; prog_data = 8'h0C;
    tick();
    check("run_ready", {31'd0, prog_ready}, 0);
    tick();
    prog_valid = 0;
    halt_req = 1; tick(); halt_req = 0;
    check("halt_state", {30'd0, state_o}, 0);
    check("halt_pc", {28'd0, pc_o}, 3);
    tick();
    check("halt_pc_frozen", {28'd0, pc_o}, 3);
    do_start();
    run_until_done(e);
    check("imem_kept_edges", e, 10);

    do_start();
    tick(); tick(); tick();
    do_reset();
    do_start();
    run_until_done(e);
    check("rst_imem_halt_edges", e, 1);

    do_reset();
    for (int i = 0; i < 8; i++) load(i, sgn[i]);
    for (int i = 0; i < 7; i++) begin
      step = 1; tick(); step = 0;
      check($sformatf("sgn_acc%0d", i), {24'd0, acc_o}, sgn_acc[i]);
    end
    step = 1; tick(); step = 0;
    check("step_halt_done", {30'd0, state_o}, 2);
    step = 1; tick(); step = 0;
    check("step_in_done", {30'd0, state_o}, 2);
    check("step_in_done_pc", {28'd0, pc_o}, 7);

    for (int i = 0; i < 16; i++) begin
      do op = $urandom_range(0, 15); while (op == 3 || op == 12);
      load(i, $urandom_range(0, 15) * 16 + op);
    end
    do_start();
    run_until_done(e);
    check("fall_edges", e, 16);
    check("fall_pc", {28'd0, pc_o}, 15);

    for (int p = 0; p < 25; p++) begin
      for (int a = 0; a < 16; a++) load(a, $urandom_range(0, 255));
      for (int c = 0; c < 60; c++) begin
        start      = ($urandom_range(0, 9) == 0);
        step       = ($urandom_range(0, 2) == 0);
        halt_req   = ($urandom_range(0, 7) == 0);
        prog_valid = ($urandom_range(0, 5) == 0);
        prog_addr  = 4'($urandom);
        prog_data  = 8'($urandom);
        dbg_addr   = 4'($urandom);
        tick();
      end
      clear_inputs();
      if (p % 8 == 7) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
